// File: rtl/fpadd_issue_ctrl.sv
// rtl/fpadd_issue_ctrl.sv - valid/ready issue control and FWFT result FIFO around a fixed-latency FP32 adder
// Optional per-operation tag path is built when FPADD_TAG_EN is defined.
module fpadd_issue_ctrl #(
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 in_a,
    input  logic [31:0]                 in_b,
`ifdef FPADD_TAG_EN
    input  logic [TAG_W-1:0]            in_tag,
    output logic [TAG_W-1:0]            res_tag,
`endif
    output logic [31:0]                 add_a,
    output logic [31:0]                 add_b,
    input  logic [31:0]                 add_out,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [31:0]                 res_data,
    output logic [$clog2(FIFO_DEPTH):0] res_count,
    output logic                        idle
);
`ifdef FPADD_TAG_EN
    localparam int TAG_USE = 1;
`else
    localparam int TAG_USE = 0;
`endif
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 32 + TAG_USE * TAG_W;

    logic [LATENCY-1:0] vpipe_q, vpipe_d;
    logic [PW-1:0]      wptr_q, wptr_d;
    logic [PW-1:0]      rptr_q, rptr_d;
    logic [PW:0]        count_q, count_d;
    logic [EW-1:0]      mem_q [FIFO_DEPTH];
    logic [EW-1:0]      mem_d [FIFO_DEPTH];
    logic [EW-1:0]      push_word;
    logic [EW-1:0]      head;
    logic               acc, push, pop;
`ifdef FPADD_TAG_EN
    logic [TAG_W-1:0]   tpipe_q [LATENCY];
    logic [TAG_W-1:0]   tpipe_d [LATENCY];
`endif

    assign add_a     = in_a;
    assign add_b     = in_b;
    assign push      = vpipe_q[LATENCY-1];
    assign res_valid = (count_q != '0);
    assign pop       = res_valid & res_ready;
    assign acc       = in_valid & in_ready;
    assign head      = mem_q[rptr_q];
    assign res_data  = res_valid ? head[31:0] : 32'd0;
    assign res_count = count_q;
    assign idle      = (count_q == '0) && (vpipe_q == '0);

`ifdef FPADD_TAG_EN
    assign push_word = {tpipe_q[LATENCY-1], add_out};
    assign res_tag   = res_valid ? head[EW-1:32] : '0;
`else
    assign push_word = add_out;
`endif

    always_comb begin
        // Every in-flight op already owns a FIFO slot, so a push can never find the FIFO full.
        in_ready = !flush && ((int'(count_q) + $countones(vpipe_q)) < FIFO_DEPTH);

        vpipe_d[0] = acc;
        for (int i = 1; i < LATENCY; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end
`ifdef FPADD_TAG_EN
        tpipe_d[0] = in_tag;
        for (int i = 1; i < LATENCY; i++) begin
            tpipe_d[i] = tpipe_q[i-1];
        end
`endif

        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            mem_d[wptr_q] = push_word;
            wptr_d        = wptr_q + {{(PW-1){1'b0}}, 1'b1};
        end
        if (pop) begin
            rptr_d = rptr_q + {{(PW-1){1'b0}}, 1'b1};
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + {{PW{1'b0}}, 1'b1};
        end else if (pop && !push) begin
            count_d = count_q - {{PW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            vpipe_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            vpipe_q <= vpipe_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
        // Storage is gated by count/vpipe, so its contents need no clearing.
        mem_q <= mem_d;
`ifdef FPADD_TAG_EN
        tpipe_q <= tpipe_d;
`endif
    end

endmodule

// File: doc/fpadd_issue_ctrl.md
Name: fpadd_issue_ctrl

Overview:
- Stream controller that wraps the single-cycle FP32 adder (`fpadd_single`) for valid/ready streams.
- Accepts operand pairs over a valid/ready input port and drives them onto the adder's `reg_A`/`reg_B`.
- Tracks in-flight operations with a valid shift register matched to the adder latency.
- Captures each adder `out` value into a FIFO with first-word-fall-through (FWFT) read and a valid/ready result port.
- Credit-based acceptance guarantees the FIFO never overflows, so results are never dropped under backpressure.

Parameters:
- LATENCY, 2, clock edges from operand capture by the adder to result stable on the adder's `out`; must be ≥1.
- FIFO_DEPTH, 4, number of result FIFO entries; must be a power of 2 and ≥2.
- TAG_W, 4, width of the optional tag; used only when FPADD_TAG_EN is defined.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous reset, active-high.
- flush  in  1  synchronous clear of the FIFO and in-flight tracking.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept a pair this cycle.
- in_a  in  32  operand A, FP32.
- in_b  in  32  operand B, FP32.
- add_a  out  32  to adder `reg_A`; combinational copy of in_a.
- add_b  out  32  to adder `reg_B`; combinational copy of in_b.
- add_out  in  32  from adder `out`.
- res_valid  out  1  FIFO head is valid.
- res_ready  in  1  consumer takes the head.
- res_data  out  32  FIFO head, FP32 sum.
- res_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- idle  out  1  FIFO empty and nothing in flight.

Behaviour:
- One clock domain.
- Reset is synchronous and active-high; it clears:
  - pipe valid bits `vpipe[LATENCY-1:0]`;
  - FIFO read/write pointers and count.
- Reset values: in_ready=1, res_valid=0, res_data=0, res_count=0, idle=1.
- Accept: `acc = in_valid & in_ready`.
  - The adder captures add_a/add_b on the same edge.
  - `vpipe[0] <= acc`; `vpipe[i] <= vpipe[i-1]`.
- Result push: while `vpipe[LATENCY-1]=1`, add_out holds that operation's sum.
  - On the next edge, add_out is written at the FIFO write pointer.
  - Total latency from accept edge to res_valid high is LATENCY+1 edges (3 at default).
- Ordering: results leave the FIFO strictly in acceptance order.
- Credit: `inflight` = popcount of vpipe.
  - `in_ready = (res_count + inflight) < FIFO_DEPTH`.
  - in_ready is registered-state only: it does not depend on res_ready or in_valid in the same cycle, and does not look ahead at a same-cycle pop.
- Pop: `pop = res_valid & res_ready`.
  - res_data is the FWFT head.
  - res_data is 0 whenever the FIFO is empty.
- Simultaneous push and pop: the count is unchanged and both pointers advance.
  - This holds when full (push allowed because credit reserved the slot).
  - When empty, the pushed word becomes visible the next cycle; there is no bypass.
- Pointers wrap modulo FIFO_DEPTH.
- No overflow is possible by construction.
  - Pop when empty is ignored (res_valid=0 anyway).
- flush=1 has the same effect as reset on vpipe and the FIFO.
  - Operations accepted before the flush edge are discarded even though the adder still produces them.
  - in_ready=0 during the flush cycle.
  - flush and reset asserted together: reset dominates (identical effect).
- Reset mid-operation: in-flight results are discarded, because the adder's out is ignored unless vpipe marks it valid.
- `idle = (res_count==0) & (vpipe==0)`.
- The controller passes data through unmodified: no arithmetic on FP fields.
  - Operand normality is the producer's responsibility; no checks are performed.

Optional Feature:
- Macro FPADD_TAG_EN.
- Defined:
  - adds ports `in_tag` (in, TAG_W) and `res_tag` (out, TAG_W);
  - the tag travels through a TAG_W-wide shift register alongside vpipe and is stored in the FIFO with the sum;
  - res_tag is aligned with res_data and is 0 when the FIFO is empty.
- Not defined: the ports, tag shift register and tag FIFO storage are absent; all other behaviour is identical.

Test Plan:
- Single op: in_a=0x3FC00000 (1.5), in_b=0x3FC00000, one-cycle in_valid, res_ready=1 -> res_valid high 3 edges later, res_data=0x40400000, idle returns to 1.
- Cancel to zero: 0x3F800000 + 0xBF800000 -> res_data=0x00000000.
- Back-to-back streaming: 8 pairs (1.0 + k.0, k=1..8), res_ready=1 -> in_ready stays 1; 8 results in order, first 0x40000000 (2.0), last 0x41100000 (9.0); one result per cycle.
- Backpressure, res_ready=0: push pairs continuously -> exactly 4 accepted; in_ready drops after the 4th accept; res_count reaches 4; no loss. Raise res_ready -> 4 results in order; in_ready reasserts the cycle after the first pop.
- Full with simultaneous push and pop: FIFO at 3 plus 1 in flight, res_ready=1 on the push edge -> res_count stays 3, no overflow, order preserved.
- Flush and reset mid-op: accept 2 pairs, assert flush one cycle later -> no res_valid afterwards, idle=1, res_count=0. Repeat with reset -> same result; a new op afterwards completes with the correct value.
